// File: rtl/button_event_ctrl_if.sv
// Event handshake between the button scheduler (master) and the
// top-level control FSM (slave). One event per valid/ready handshake.
interface button_event_ctrl_if;
   logic       oEvtValid;
   logic [2:0] oEvtId;
   logic       oEvtRepeat;
   logic       iEvtReady;

   modport master (
      output oEvtValid,
      output oEvtId,
      output oEvtRepeat,
      input  iEvtReady
   );

   modport slave (
      input  oEvtValid,
      input  oEvtId,
      input  oEvtRepeat,
      output iEvtReady
   );
endinterface

// File: rtl/button_event_ctrl.sv
// Front-panel button scheduler: produces the sampling tick for the button
// synchronizers, turns press pulses and long holds into press/repeat events,
// and hands the events one at a time to the control FSM in round-robin order.
module button_event_ctrl #(
   parameter int NUM_BTN     = 4,
   parameter int TICK_DIV    = 50000,
   parameter int REPEAT_DLY  = 50,
   parameter int REPEAT_RATE = 10
) (
   input  logic                iClk,
   input  logic                iRsn,
   input  logic                iEnable,
   output logic                oEnClk,
   input  logic [NUM_BTN-1:0]  iBtnEdge,
   input  logic [NUM_BTN-1:0]  iBtnLevel,
   button_event_ctrl_if.master evt,
   output logic [7:0]          oDropCnt
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(REPEAT_DLY + 1);

   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW:0]   HOLD_FIRE   = (HW+1)'(REPEAT_DLY);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DLY - REPEAT_RATE);
   localparam logic [2:0]    PTR_INIT    = 3'(NUM_BTN - 1);

   typedef enum logic {
      ST_IDLE,
      ST_OFFER
   } state_t;

   // prescaler
   logic [PW-1:0]      presc_q, presc_d;
   logic               tick;

   // per-button hold counters and pending slots
   logic [HW-1:0]      hold_q [NUM_BTN];
   logic [HW-1:0]      hold_d [NUM_BTN];
   logic [NUM_BTN-1:0] pend_q, pend_d;
   logic [NUM_BTN-1:0] pend_rep_q, pend_rep_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;

   // arbiter / offer FSM
   state_t             state_q, state_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         evt_id_q, evt_id_d;
   logic               evt_rep_q, evt_rep_d;
   logic [NUM_BTN-1:0] grant;

   // Free-running tick divider; held at zero while disabled so a re-enable
   // always starts a full period.
   always_comb begin
      tick    = iEnable && (presc_q == PRESC_LAST);
      presc_d = presc_q + PW'(1);
      if (!iEnable || tick) begin
         presc_d = '0;
      end
   end

   // Per-button event generation, pending-slot update and drop counting.
   // A new event replaces a slot only if the slot is free or being granted
   // in this very cycle; otherwise it is discarded and counted as a drop.
   always_comb begin : button_next
      logic [HW:0] hold_inc;
      logic        press_evt;
      logic        rep_evt;
      logic        drop_any;
      hold_inc   = '0;
      press_evt  = 1'b0;
      rep_evt    = 1'b0;
      drop_any   = 1'b0;
      pend_d     = pend_q;
      pend_rep_d = pend_rep_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         hold_d[i] = hold_q[i];
         hold_inc  = {1'b0, hold_q[i]} + (HW+1)'(1);
         press_evt = iEnable & iBtnEdge[i];
         rep_evt   = 1'b0;
         if (!iEnable || iBtnLevel[i]) begin
            hold_d[i] = '0;
         end else if (iBtnEdge[i]) begin
            // a fresh press restarts the hold timing
            hold_d[i] = '0;
         end else if (tick) begin
            if (hold_inc == HOLD_FIRE) begin
               // reload so the next repeat lands REPEAT_RATE ticks later
               rep_evt   = 1'b1;
               hold_d[i] = HOLD_RELOAD;
            end else begin
               hold_d[i] = hold_inc[HW-1:0];
            end
         end
         if ((press_evt || rep_evt) && pend_q[i] && !grant[i]) begin
            drop_any = 1'b1;
         end else if (press_evt || rep_evt) begin
            pend_d[i]     = 1'b1;
            pend_rep_d[i] = rep_evt;
         end else if (grant[i]) begin
            pend_d[i]     = 1'b0;
            pend_rep_d[i] = 1'b0;
         end
      end
      drop_cnt_d = drop_cnt_q;
      if (drop_any && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Offer FSM next state: round-robin pick from the pointer upward with
   // wrap, then hold the chosen event stable until it is accepted.
   always_comb begin : fsm_next
      logic [7:0] pend8;
      logic [7:0] rep8;
      logic [7:0] grant8;
      logic [3:0] pos;
      logic       found;
      logic [2:0] sel;
      state_d   = state_q;
      ptr_d     = ptr_q;
      evt_id_d  = evt_id_q;
      evt_rep_d = evt_rep_q;
      pend8     = '0;
      rep8      = '0;
      grant8    = '0;
      pos       = '0;
      found     = 1'b0;
      sel       = '0;
      pend8[NUM_BTN-1:0] = pend_q;
      rep8[NUM_BTN-1:0]  = pend_rep_q;
      for (int k = 1; k <= NUM_BTN; k++) begin
         pos = {1'b0, ptr_q} + 4'(k);
         if (pos >= 4'(NUM_BTN)) begin
            pos = pos - 4'(NUM_BTN);
         end
         if (!found && pend8[pos[2:0]]) begin
            found = 1'b1;
            sel   = pos[2:0];
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d   = ST_OFFER;
               evt_id_d  = sel;
               evt_rep_d = rep8[sel];
            end
         end
         ST_OFFER: begin
            if (evt.iEvtReady) begin
               grant8[evt_id_q] = 1'b1;
               ptr_d            = evt_id_q;
               state_d          = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      grant = grant8[NUM_BTN-1:0];
   end

   // Offer FSM state register.
   always_ff @(posedge iClk) begin
      if (!iRsn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PTR_INIT;
         evt_id_q  <= '0;
         evt_rep_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         evt_id_q  <= evt_id_d;
         evt_rep_q <= evt_rep_d;
      end
   end

   // Prescaler, hold counters, pending slots and drop counter registers.
   always_ff @(posedge iClk) begin
      if (!iRsn) begin
         presc_q    <= '0;
         hold_q     <= '{default: '0};
         pend_q     <= '0;
         pend_rep_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         presc_q    <= presc_d;
         hold_q     <= hold_d;
         pend_q     <= pend_d;
         pend_rep_q <= pend_rep_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign oEnClk         = tick;
   assign evt.oEvtValid  = (state_q == ST_OFFER);
   assign evt.oEvtId     = evt_id_q;
   assign evt.oEvtRepeat = evt_rep_q;
   assign oDropCnt       = drop_cnt_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus a randomized run,
// all compared against an event-level reference model of the scheduler.
module tb_button_event_ctrl;

   localparam int NB   = 4;
   localparam int TD   = 4;
   localparam int DLY  = 3;
   localparam int RATE = 2;

   logic          clk = 1'b0;
   logic          rsn;
   logic          en;
   logic [NB-1:0] edge_v;
   logic [NB-1:0] lvl_v;
   logic          en_clk;
   logic [7:0]    drop_cnt;

   int errors = 0;
   int checks = 0;

   button_event_ctrl_if evt_bus ();

   button_event_ctrl #(
      .NUM_BTN     (NB),
      .TICK_DIV    (TD),
      .REPEAT_DLY  (DLY),
      .REPEAT_RATE (RATE)
   ) dut (
      .iClk      (clk),
      .iRsn      (rsn),
      .iEnable   (en),
      .oEnClk    (en_clk),
      .iBtnEdge  (edge_v),
      .iBtnLevel (lvl_v),
      .evt       (evt_bus.master),
      .oDropCnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_cnt;           // enabled cycles since last restart, mod TD
   int m_held [NB];     // ticks held low since press / last clear
   bit m_pend [NB];
   bit m_kind [NB];
   bit m_busy;
   int m_id;
   bit m_rep;
   int m_last;
   int m_drops;

   task automatic model_reset();
      m_cnt = 0;
      for (int i = 0; i < NB; i++) begin
         m_held[i] = 0;
         m_pend[i] = 1'b0;
         m_kind[i] = 1'b0;
      end
      m_busy  = 1'b0;
      m_id    = 0;
      m_rep   = 1'b0;
      m_last  = NB - 1;
      m_drops = 0;
   endtask

   function automatic bit exp_enclk();
      return en && (m_cnt == TD - 1);
   endfunction

   task automatic model_step();
      bit old_pend [NB];
      bit old_kind [NB];
      bit tk, press, rep, dropped, found;
      int gid, j;
      if (!rsn) begin
         model_reset();
         return;
      end
      tk  = exp_enclk();
      gid = (m_busy && evt_bus.iEvtReady) ? m_id : -1;
      old_pend = m_pend;
      old_kind = m_kind;
      dropped  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         press = en && edge_v[i];
         rep   = 1'b0;
         if (!en || lvl_v[i]) m_held[i] = 0;
         else if (press) m_held[i] = 0;
         else if (tk) begin
            m_held[i]++;
            rep = (m_held[i] >= DLY) && (((m_held[i] - DLY) % RATE) == 0);
         end
         if (press || rep) begin
            if (m_pend[i] && gid != i) dropped = 1'b1;
            else begin
               m_pend[i] = 1'b1;
               m_kind[i] = rep;
            end
         end else if (gid == i) begin
            m_pend[i] = 1'b0;
         end
      end
      if (dropped && m_drops < 255) m_drops++;
      if (m_busy) begin
         if (evt_bus.iEvtReady) begin
            m_busy = 1'b0;
            m_last = m_id;
         end
      end else begin
         found = 1'b0;
         for (int k = 1; k <= NB; k++) begin
            j = (m_last + k) % NB;
            if (!found && old_pend[j]) begin
               found  = 1'b1;
               m_busy = 1'b1;
               m_id   = j;
               m_rep  = old_kind[j];
            end
         end
      end
      m_cnt = en ? (m_cnt + 1) % TD : 0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic r, input logic e, input logic [NB-1:0] ed,
                        input logic [NB-1:0] lv, input logic rd);
      rsn    = r;
      en     = e;
      edge_v = ed;
      lvl_v  = lv;
      evt_bus.iEvtReady = rd;
      #1;
   endtask

   task automatic clk_step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, '0, '1, 1'b0);
      clk_step();
      clk_step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (evt_bus.oEvtValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_bus.oEvtValid); end
      checks++; if (evt_bus.oEvtId !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", evt_bus.oEvtId); end
      checks++; if (evt_bus.oEvtRepeat !== 1'b0) begin errors++; $display("FAIL reset_repeat: got %b expected 0", evt_bus.oEvtRepeat); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
      checks++; if (en_clk !== 1'b0) begin errors++; $display("FAIL reset_enclk: got %b expected 0", en_clk); end
   endtask

   task automatic test_prescaler();
      do_reset();
      for (int c = 0; c < 14; c++) begin
         drive(1'b1, 1'b1, '0, '1, 1'b0);
         checks++;
         if (en_clk !== ((c % TD) == TD - 1)) begin
            errors++; $display("FAIL presc_tick c=%0d: got %b expected %b", c, en_clk, (c % TD) == TD - 1);
         end
         clk_step();
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, '0, '1, 1'b0);
         checks++;
         if (en_clk !== 1'b0) begin errors++; $display("FAIL presc_disabled c=%0d: got %b expected 0", c, en_clk); end
         clk_step();
      end
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 1'b1, '0, '1, 1'b0);
         checks++;
         if (en_clk !== ((c % TD) == TD - 1)) begin
            errors++; $display("FAIL presc_restart c=%0d: got %b expected %b", c, en_clk, (c % TD) == TD - 1);
         end
         clk_step();
      end
   endtask

   task automatic test_single_press();
      drive(1'b1, 1'b1, 4'b0100, '1, 1'b1);
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b1);
      checks++; if (evt_bus.oEvtValid !== 1'b0) begin errors++; $display("FAIL press_t1_valid: got %b expected 0", evt_bus.oEvtValid); end
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b1);
      checks++; if (evt_bus.oEvtValid !== 1'b1) begin errors++; $display("FAIL press_t2_valid: got %b expected 1", evt_bus.oEvtValid); end
      checks++; if (evt_bus.oEvtId !== 3'd2) begin errors++; $display("FAIL press_t2_id: got %0d expected 2", evt_bus.oEvtId); end
      checks++; if (evt_bus.oEvtRepeat !== 1'b0) begin errors++; $display("FAIL press_t2_repeat: got %b expected 0", evt_bus.oEvtRepeat); end
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b1);
      checks++; if (evt_bus.oEvtValid !== 1'b0) begin errors++; $display("FAIL press_t3_valid: got %b expected 0", evt_bus.oEvtValid); end
   endtask

   task automatic test_round_robin();
      int got [$];
      int want1 [3] = '{0, 1, 3};
      int want2 [2] = '{0, 3};
      do_reset();
      drive(1'b1, 1'b1, 4'b1011, '1, 1'b1);
      clk_step();
      for (int c = 0; c < 12; c++) begin
         drive(1'b1, 1'b1, '0, '1, 1'b1);
         if (evt_bus.oEvtValid === 1'b1) got.push_back(int'(evt_bus.oEvtId));
         clk_step();
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL rr1_count: got %0d expected 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checks++; if (got[k] != want1[k]) begin errors++; $display("FAIL rr1_order[%0d]: got %0d expected %0d", k, got[k], want1[k]); end
      end
      got.delete();
      drive(1'b1, 1'b1, 4'b1001, '1, 1'b1);
      clk_step();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 1'b1, '0, '1, 1'b1);
         if (evt_bus.oEvtValid === 1'b1) got.push_back(int'(evt_bus.oEvtId));
         clk_step();
      end
      checks++; if (got.size() != 2) begin errors++; $display("FAIL rr2_count: got %0d expected 2", got.size()); end
      for (int k = 0; k < 2 && k < got.size(); k++) begin
         checks++; if (got[k] != want2[k]) begin errors++; $display("FAIL rr2_order[%0d]: got %0d expected %0d", k, got[k], want2[k]); end
      end
   endtask

   task automatic test_repeat();
      int ticks = 0;
      int ids [$];
      int reps [$];
      int at [$];
      int want_rep [4] = '{0, 1, 1, 1};
      int want_at [4]  = '{0, 3, 5, 7};
      do_reset();
      for (int c = 0; c < 60; c++) begin
         drive(1'b1, 1'b1, (c == 0) ? 4'b0010 : 4'b0000, (ticks >= 8) ? 4'b1111 : 4'b1101, 1'b1);
         checks++;
         if (en_clk !== exp_enclk()) begin errors++; $display("FAIL rep_enclk c=%0d: got %b expected %b", c, en_clk, exp_enclk()); end
         if (evt_bus.oEvtValid === 1'b1) begin
            ids.push_back(int'(evt_bus.oEvtId));
            reps.push_back(int'(evt_bus.oEvtRepeat));
            at.push_back(ticks);
         end
         if (exp_enclk()) ticks++;
         clk_step();
      end
      checks++; if (ids.size() != 4) begin errors++; $display("FAIL rep_count: got %0d expected 4", ids.size()); end
      for (int k = 0; k < 4 && k < ids.size(); k++) begin
         checks++;
         if (ids[k] != 1 || reps[k] != want_rep[k] || at[k] != want_at[k]) begin
            errors++;
            $display("FAIL rep_event[%0d]: got id=%0d rep=%0d after_tick=%0d expected id=1 rep=%0d after_tick=%0d",
                     k, ids[k], reps[k], at[k], want_rep[k], want_at[k]);
         end
      end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rep_drop: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_drop_stall();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 1'b1, (c == 0 || c == 2 || c == 4) ? 4'b0100 : 4'b0000, '1, 1'b0);
         if (c >= 2) begin
            checks++;
            if (evt_bus.oEvtValid !== 1'b1 || evt_bus.oEvtId !== 3'd2) begin
               errors++; $display("FAIL stall_hold c=%0d: got valid=%b id=%0d expected valid=1 id=2", c, evt_bus.oEvtValid, evt_bus.oEvtId);
            end
         end
         clk_step();
      end
      drive(1'b1, 1'b1, '0, '1, 1'b0);
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_two: got %0d expected 2", drop_cnt); end
      for (int c = 0; c < 300; c++) begin
         drive(1'b1, 1'b1, 4'b0100, '1, 1'b0);
         clk_step();
      end
      drive(1'b1, 1'b1, '0, '1, 1'b0);
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
      checks++;
      if (evt_bus.oEvtValid !== 1'b1 || evt_bus.oEvtId !== 3'd2 || evt_bus.oEvtRepeat !== 1'b0) begin
         errors++; $display("FAIL drop_offer: got valid=%b id=%0d rep=%b expected valid=1 id=2 rep=0",
                            evt_bus.oEvtValid, evt_bus.oEvtId, evt_bus.oEvtRepeat);
      end
   endtask

   task automatic test_reset_mid_offer();
      do_reset();
      drive(1'b1, 1'b1, 4'b1000, '1, 1'b0);
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b0);
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b0);
      checks++; if (evt_bus.oEvtValid !== 1'b1 || evt_bus.oEvtId !== 3'd3) begin
         errors++; $display("FAIL rstoff_pre: got valid=%b id=%0d expected valid=1 id=3", evt_bus.oEvtValid, evt_bus.oEvtId);
      end
      drive(1'b0, 1'b1, '0, '1, 1'b0);
      clk_step();
      drive(1'b1, 1'b1, '0, '1, 1'b1);
      checks++; if (evt_bus.oEvtValid !== 1'b0) begin errors++; $display("FAIL rstoff_valid: got %b expected 0", evt_bus.oEvtValid); end
      checks++; if (evt_bus.oEvtId !== 3'd0) begin errors++; $display("FAIL rstoff_id: got %0d expected 0", evt_bus.oEvtId); end
      checks++; if (evt_bus.oEvtRepeat !== 1'b0) begin errors++; $display("FAIL rstoff_repeat: got %b expected 0", evt_bus.oEvtRepeat); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rstoff_drop: got %0d expected 0", drop_cnt); end
      checks++; if (en_clk !== 1'b0) begin errors++; $display("FAIL rstoff_enclk: got %b expected 0", en_clk); end
      for (int c = 0; c < 6; c++) begin
         clk_step();
         drive(1'b1, 1'b1, '0, '1, 1'b1);
         checks++; if (evt_bus.oEvtValid !== 1'b0) begin errors++; $display("FAIL rstoff_stale c=%0d: got %b expected 0", c, evt_bus.oEvtValid); end
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] lvl_r = '1;
      logic [NB-1:0] ed_r;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 19) == 0) lvl_r[b] = ~lvl_r[b];
            ed_r[b] = ($urandom_range(0, 23) == 0);
         end
         drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0), ed_r, lvl_r, 1'($urandom_range(0, 1)));
         checks++; if (en_clk !== exp_enclk()) begin errors++; $display("FAIL rnd_enclk c=%0d: got %b expected %b", c, en_clk, exp_enclk()); end
         checks++; if (evt_bus.oEvtValid !== m_busy) begin errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, evt_bus.oEvtValid, m_busy); end
         checks++; if (evt_bus.oEvtId !== 3'(m_id)) begin errors++; $display("FAIL rnd_id c=%0d: got %0d expected %0d", c, evt_bus.oEvtId, m_id); end
         checks++; if (evt_bus.oEvtRepeat !== m_rep) begin errors++; $display("FAIL rnd_repeat c=%0d: got %b expected %b", c, evt_bus.oEvtRepeat, m_rep); end
         checks++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL rnd_drop c=%0d: got %0d expected %0d", c, drop_cnt, m_drops); end
         clk_step();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_prescaler();
      test_single_press();
      test_round_robin();
      test_repeat();
      test_drop_stall();
      test_reset_mid_offer();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
